// File: rtl/dual_bus_mem_bridge.sv
// Arbitrates an instruction read port and a data read/write port onto one
// single-outstanding memory request channel, rebasing addresses by BASE_ADDR.
module dual_bus_mem_bridge #(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000,
  parameter int              PRIO_RR   = 0,
  localparam int             MW        = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ibus_req,
  input  logic [AW-1:0] ibus_addr,
  output logic [DW-1:0] ibus_rdata,
  output logic          ibus_ready,
  input  logic          dbus_req,
  input  logic          dbus_we,
  input  logic [AW-1:0] dbus_addr,
  input  logic [DW-1:0] dbus_wdata,
  input  logic [MW-1:0] dbus_mask,
  output logic [DW-1:0] dbus_rdata,
  output logic          dbus_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [MW-1:0] mem_mask,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_dbus_q, gnt_dbus_d;
  logic          last_dbus_q, last_dbus_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] mask_q, mask_d;
  logic [DW-1:0] irdata_q, irdata_d;
  logic [DW-1:0] drdata_q, drdata_d;
  logic          pick_dbus;

  // Round-robin only matters on a tie: the port not served last goes first.
  always_comb begin
    if ((PRIO_RR != 0) && ibus_req && dbus_req) begin
      pick_dbus = !last_dbus_q;
    end else begin
      pick_dbus = dbus_req;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_dbus_d  = gnt_dbus_q;
    last_dbus_d = last_dbus_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    case (state_q)
      IDLE: begin
        if (ibus_req || dbus_req) begin
          state_d     = REQ;
          gnt_dbus_d  = pick_dbus;
          last_dbus_d = pick_dbus;
          if (pick_dbus) begin
            we_d    = dbus_we;
            addr_d  = dbus_addr - BASE_ADDR;
            wdata_d = dbus_wdata;
            mask_d  = dbus_mask;
          end else begin
            we_d    = 1'b0;
            addr_d  = ibus_addr - BASE_ADDR;
            wdata_d = '0;
            mask_d  = '1;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!we_q) begin
            if (gnt_dbus_q) drdata_d = mem_rdata;
            else            irdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_dbus_q  <= 1'b0;
      last_dbus_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_dbus_q  <= gnt_dbus_d;
      last_dbus_q <= last_dbus_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign mem_req    = (state_q == REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_mask   = mask_q;
  assign ibus_rdata = irdata_q;
  assign dbus_rdata = drdata_q;
  assign ibus_ready = (state_q == RESP) && !gnt_dbus_q;
  assign dbus_ready = (state_q == RESP) && gnt_dbus_q;

endmodule

// File: doc/dual_bus_mem_bridge.md
DUAL_BUS_MEM_BRIDGE -- requirements
Module: dual_bus_mem_bridge

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; MW = DW/8 byte-mask width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h8000_0000, guest physical base subtracted from core addresses.
REQ-004 SHALL have parameter PRIO_RR, default 0; 0 = fixed dbus priority, 1 = round-robin.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ibus_req  in  1  instruction read request, held until ibus_ready.
REQ-008 SHALL have port ibus_addr  in  AW  instruction address.
REQ-009 SHALL have port ibus_rdata  out  DW  instruction read data, registered.
REQ-010 SHALL have port ibus_ready  out  1  one-cycle completion pulse.
REQ-011 SHALL have port dbus_req  in  1  data request, held until dbus_ready.
REQ-012 SHALL have port dbus_we  in  1  1 = write, 0 = read.
REQ-013 SHALL have port dbus_addr  in  AW  data address.
REQ-014 SHALL have port dbus_wdata  in  DW  write data.
REQ-015 SHALL have port dbus_mask  in  MW  byte-write enables.
REQ-016 SHALL have port dbus_rdata  out  DW  data read result, registered.
REQ-017 SHALL have port dbus_ready  out  1  one-cycle completion pulse.
REQ-018 SHALL have port mem_req  out  1  memory request, held until mem_ack.
REQ-019 SHALL have ports mem_we (1), mem_addr (AW), mem_wdata (DW), mem_mask (MW), all out, the latched transaction payload.
REQ-020 SHALL have port mem_rdata  in  DW  memory read data, valid with mem_ack.
REQ-021 SHALL have port mem_ack  in  1  memory completion, sampled while mem_req=1.

Function
REQ-022 SHALL implement FSM with states IDLE, REQ and RESP.
REQ-023 In IDLE, with any request pending, SHALL grant one port, latch its payload at the clock edge and enter REQ.
REQ-024 Grant, PRIO_RR=0: dbus wins when both ports request.
REQ-025 Grant, PRIO_RR=1: on a tie, the port not granted last wins; last_grant updates on each grant and resets to ibus.
REQ-026 Latched payload for ibus: we=0, mask=all ones, wdata=0.
REQ-027 mem_addr SHALL equal latched address minus BASE_ADDR, truncated modulo 2^AW (wrap on underflow, no error).
REQ-028 In REQ: mem_req=1 with stable payload every cycle until mem_ack=1; there is no timeout.
REQ-029 On mem_ack in REQ: capture mem_rdata into the granted port's rdata (reads only; writes leave rdata unchanged), then enter RESP.
REQ-030 In RESP: mem_req=0; the granted port's ready=1 for exactly this cycle; no new grant; next state IDLE.
REQ-031 Minimum latency SHALL be 3 cycles: req sampled at edge 0, mem_req high in cycle 1, ack in cycle 1, ready in cycle 2.
REQ-032 A request deasserted before grant SHALL be ignored; payload changes after grant SHALL have no effect.
REQ-033 mem_ack outside REQ SHALL be ignored.
REQ-034 The two ready signals SHALL never be asserted in the same cycle.

Reset
REQ-035 rst=0 SHALL immediately force: state IDLE, mem_req=0, mem_we=0, mem_addr/mem_wdata/mem_mask=0, both rdata=0, both ready=0, last_grant=ibus.
REQ-036 Reset mid-transaction SHALL abort it with no ready pulse; after rst rises, first grant occurs at the first edge with a request.

Verification
REQ-037 ibus_req, addr 0x8000_0004; mem_ack same cycle mem_req rises, mem_rdata 0x0000_0013 -> mem_addr 0x4, ibus_ready in cycle 2, ibus_rdata 0x13.
REQ-038 dbus write addr 0x8000_0100, wdata 0xDEAD_BEEF, mask 0x3; ack after 4 wait cycles -> payload stable for 5 cycles, mem_we=1, mem_mask 0x3, dbus_rdata unchanged.
REQ-039 PRIO_RR=0, both request continuously -> dbus granted back-to-back; ibus starves.
REQ-040 PRIO_RR=1, both request continuously -> grants alternate dbus, ibus, dbus; one ready per transaction.
REQ-041 Address 0x0000_0010 -> mem_addr 0x8000_0010 (wrap); rst low while in REQ -> mem_req drops without waiting for clk, no ready pulse.
